// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch-side bundle for the program-counter generator.
//   master : drives hold, redirect requests/targets, step size and memory ready.
//            Observes the fetch request, PC, flush, redirect source and misalign flag.
//   slave  : the pc_gen side of the same signals.
interface pc_gen_if #(
    parameter int XLEN      = 32,
    parameter int NUM_REDIR = 2
);
    localparam int SRCW = (NUM_REDIR > 1) ? $clog2(NUM_REDIR) : 1;

    logic                      hold_i;
    logic [NUM_REDIR-1:0]      redir_en_i;
    logic [NUM_REDIR*XLEN-1:0] redir_addr_i;
    logic                      step_c_i;
    logic                      fetch_ready_i;
    logic                      fetch_valid_o;
    logic [XLEN-1:0]           pc_o;
    logic                      flush_o;
    logic [SRCW-1:0]           redir_src_o;
    logic                      misalign_o;

    modport master (
        output hold_i, redir_en_i, redir_addr_i, step_c_i, fetch_ready_i,
        input  fetch_valid_o, pc_o, flush_o, redir_src_o, misalign_o
    );

    modport slave (
        input  hold_i, redir_en_i, redir_addr_i, step_c_i, fetch_ready_i,
        output fetch_valid_o, pc_o, flush_o, redir_src_o, misalign_o
    );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program-counter generator.
//   clk, rstn : clock, asynchronous active-low reset.
//   bus       : pc_gen_if.slave
//     hold_i        stall: freezes PC, withdraws fetch request
//     redir_en_i    per-channel redirect request, channel 0 highest priority
//     redir_addr_i  redirect targets, channel k at [k*XLEN +: XLEN]
//     step_c_i      current instruction is 16-bit (used only when C_EXT=1)
//     fetch_ready_i instruction memory accepts the request
//     fetch_valid_o fetch request valid
//     pc_o          current fetch PC
//     flush_o       one-cycle pulse after a redirect is taken
//     redir_src_o   index of the last redirect taken
//     misalign_o    one-cycle pulse after a misaligned redirect is taken
module pc_gen #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              NUM_REDIR = 2,
    parameter int              C_EXT     = 0
) (
    input  logic      clk,
    input  logic      rstn,
    pc_gen_if.slave   bus
);
    localparam int SRCW = (NUM_REDIR > 1) ? $clog2(NUM_REDIR) : 1;
    // Bits forced to zero on a redirect target.
    localparam logic [XLEN-1:0] LOW_MASK = (C_EXT != 0) ? XLEN'(1) : XLEN'(3);

    typedef enum logic {BOOT, RUN} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic            r_flush;
    logic            r_misalign;
    logic [SRCW-1:0] r_src;

    logic            w_redir_any;
    logic [SRCW-1:0] w_win;
    logic [XLEN-1:0] w_tgt;
    logic [XLEN-1:0] w_step;
    logic            w_valid;
    logic            w_hs;

    // Scan from highest index down so the lowest set channel wins.
    always_comb begin
        w_redir_any = |bus.redir_en_i;
        w_win       = '0;
        w_tgt       = '0;
        for (int unsigned k = NUM_REDIR; k > 0; k--) begin
            if (bus.redir_en_i[k-1]) begin
                w_win = SRCW'(k - 1);
                w_tgt = bus.redir_addr_i[(k-1)*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            BOOT:    w_state_nxt = RUN;
            RUN:     w_state_nxt = RUN;
            default: w_state_nxt = BOOT;
        endcase
    end

    assign w_step  = ((C_EXT != 0) && bus.step_c_i) ? XLEN'(2) : XLEN'(4);
    assign w_valid = (r_state == RUN) & ~bus.hold_i & ~w_redir_any;
    assign w_hs    = w_valid & bus.fetch_ready_i;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= BOOT;
            r_pc       <= RESET_VEC;
            r_flush    <= 1'b0;
            r_misalign <= 1'b0;
            r_src      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_flush    <= w_redir_any;
            r_misalign <= w_redir_any & (|(w_tgt & LOW_MASK));
            if (w_redir_any) begin
                r_pc  <= w_tgt & ~LOW_MASK;
                r_src <= w_win;
            end else if (!bus.hold_i && w_hs) begin
                r_pc  <= r_pc + w_step;
            end
        end
    end

    assign bus.fetch_valid_o = w_valid;
    assign bus.pc_o          = r_pc;
    assign bus.flush_o       = r_flush;
    assign bus.redir_src_o   = r_src;
    assign bus.misalign_o    = r_misalign;
endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        hold = 1'b0;
    logic [1:0]  ren = 2'b00;
    logic [31:0] a0 = '0;
    logic [31:0] a1 = '0;
    logic        stepc = 1'b0;
    logic        rdy = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    bit sb_on    = 1'b0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    always #5 clk = ~clk;

    pc_gen_if #(.XLEN(32), .NUM_REDIR(2)) if0 ();
    pc_gen_if #(.XLEN(32), .NUM_REDIR(2)) if1 ();

    assign if0.hold_i = hold;        assign if1.hold_i = hold;
    assign if0.redir_en_i = ren;     assign if1.redir_en_i = ren;
    assign if0.redir_addr_i = {a1, a0};
    assign if1.redir_addr_i = {a1, a0};
    assign if0.step_c_i = stepc;     assign if1.step_c_i = stepc;
    assign if0.fetch_ready_i = rdy;  assign if1.fetch_ready_i = rdy;

    pc_gen #(.XLEN(32), .RESET_VEC(32'h8000_0000), .NUM_REDIR(2), .C_EXT(0))
        u_dut0 (.clk(clk), .rstn(rstn), .bus(if0.slave));
    pc_gen #(.XLEN(32), .RESET_VEC(32'h8000_0000), .NUM_REDIR(2), .C_EXT(1))
        u_dut1 (.clk(clk), .rstn(rstn), .bus(if1.slave));

    // Scoreboard consumer: every accepted fetch must match the next queued PC.
    always @(negedge clk) begin
        if (sb_on && rstn) begin
            if (if0.fetch_valid_o && rdy) begin
                n_checks++;
                if (q0.size() == 0) begin
                    n_fail++; $display("FAIL sb_c0 unexpected fetch got %h exp <none>", if0.pc_o);
                end else if (if0.pc_o !== q0[0]) begin
                    n_fail++; $display("FAIL sb_c0 got %h exp %h", if0.pc_o, q0[0]);
                    void'(q0.pop_front());
                end else void'(q0.pop_front());
            end
            if (if1.fetch_valid_o && rdy) begin
                n_checks++;
                if (q1.size() == 0) begin
                    n_fail++; $display("FAIL sb_c1 unexpected fetch got %h exp <none>", if1.pc_o);
                end else if (if1.pc_o !== q1[0]) begin
                    n_fail++; $display("FAIL sb_c1 got %h exp %h", if1.pc_o, q1[0]);
                    void'(q1.pop_front());
                end else void'(q1.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

    // One cycle of stimulus: apply just after the edge, return once combinational outputs settle.
    task automatic drv(input logic h, input logic [1:0] en, input logic [31:0] x0,
                       input logic [31:0] x1, input logic sc, input logic r);
        @(posedge clk); #1;
        hold = h; ren = en; a0 = x0; a1 = x1; stepc = sc; rdy = r;
        #1;
    endtask

    task automatic test_reset;
        rstn = 1'b0; hold = 1'b0; ren = 2'b00; stepc = 1'b0; rdy = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        n_checks++; if (if0.pc_o !== 32'h8000_0000) begin n_fail++; $display("FAIL rst_pc0 got %h exp %h", if0.pc_o, 32'h8000_0000); end
        n_checks++; if (if1.pc_o !== 32'h8000_0000) begin n_fail++; $display("FAIL rst_pc1 got %h exp %h", if1.pc_o, 32'h8000_0000); end
        n_checks++; if ({if0.flush_o, if0.misalign_o, if0.redir_src_o} !== 3'b000) begin n_fail++; $display("FAIL rst_flags got %b%b%b exp 000", if0.flush_o, if0.misalign_o, if0.redir_src_o); end
        n_checks++; if (if0.fetch_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", if0.fetch_valid_o); end
        rstn = 1'b1;
        #1;
        n_checks++; if (if0.fetch_valid_o !== 1'b0 || if1.fetch_valid_o !== 1'b0) begin n_fail++; $display("FAIL boot_valid got %b%b exp 00", if0.fetch_valid_o, if1.fetch_valid_o); end
        q0.push_back(32'h8000_0000); q0.push_back(32'h8000_0004); q0.push_back(32'h8000_0008);
        q1.push_back(32'h8000_0000); q1.push_back(32'h8000_0004); q1.push_back(32'h8000_0008);
        sb_on = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drv(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
            n_checks++; if (if0.fetch_valid_o !== 1'b1) begin n_fail++; $display("FAIL run_valid%0d got %b exp 1", i, if0.fetch_valid_o); end
        end
        drv(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
        sb_on = 1'b0;
        n_checks++; if (if0.pc_o !== 32'h8000_000C) begin n_fail++; $display("FAIL run_pc got %h exp %h", if0.pc_o, 32'h8000_000C); end
        n_checks++; if (q0.size() != 0 || q1.size() != 0) begin n_fail++; $display("FAIL reset_sb_drain got %0d/%0d exp 0/0", q0.size(), q1.size()); end
    endtask

    task automatic test_backpressure;
        drv(1'b0, 2'b01, 32'h40, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drv(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
            n_checks++; if (if0.fetch_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_valid%0d got %b exp 1", i, if0.fetch_valid_o); end
            n_checks++; if (if0.pc_o !== 32'h40 || if1.pc_o !== 32'h40) begin n_fail++; $display("FAIL bp_hold%0d got %h/%h exp %h", i, if0.pc_o, if1.pc_o, 32'h40); end
        end
        q0.push_back(32'h40); q1.push_back(32'h40);
        sb_on = 1'b1;
        drv(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
        drv(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
        sb_on = 1'b0;
        n_checks++; if (if0.pc_o !== 32'h44 || if1.pc_o !== 32'h44) begin n_fail++; $display("FAIL bp_accept got %h/%h exp %h", if0.pc_o, if1.pc_o, 32'h44); end
        n_checks++; if (q0.size() != 0 || q1.size() != 0) begin n_fail++; $display("FAIL bp_sb_drain got %0d/%0d exp 0/0", q0.size(), q1.size()); end
    endtask

    task automatic test_simultaneous;
        drv(1'b1, 2'b11, 32'h100, 32'h200, 1'b0, 1'b1);
        n_checks++; if (if0.fetch_valid_o !== 1'b0) begin n_fail++; $display("FAIL sim_valid got %b exp 0", if0.fetch_valid_o); end
        drv(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
        n_checks++; if (if0.pc_o !== 32'h100 || if1.pc_o !== 32'h100) begin n_fail++; $display("FAIL sim_pc got %h/%h exp %h", if0.pc_o, if1.pc_o, 32'h100); end
        n_checks++; if (if0.redir_src_o !== 1'b0) begin n_fail++; $display("FAIL sim_src got %0d exp 0", if0.redir_src_o); end
        n_checks++; if (if0.flush_o !== 1'b1 || if0.misalign_o !== 1'b0) begin n_fail++; $display("FAIL sim_flush got f%b m%b exp f1 m0", if0.flush_o, if0.misalign_o); end
        drv(1'b1, 2'b10, 32'h0, 32'h200, 1'b0, 1'b1);
        n_checks++; if (if0.flush_o !== 1'b0 || if0.pc_o !== 32'h100) begin n_fail++; $display("FAIL sim_pulse got f%b pc %h exp f0 pc %h", if0.flush_o, if0.pc_o, 32'h100); end
        drv(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
        n_checks++; if (if0.pc_o !== 32'h200 || if0.redir_src_o !== 1'b1) begin n_fail++; $display("FAIL ch1_redir got pc %h src %0d exp pc %h src 1", if0.pc_o, if0.redir_src_o, 32'h200); end
        drv(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
        n_checks++; if (if1.redir_src_o !== 1'b1 || if1.flush_o !== 1'b0) begin n_fail++; $display("FAIL src_hold got src %0d f%b exp src 1 f0", if1.redir_src_o, if1.flush_o); end
    endtask

    task automatic test_misaligned;
        drv(1'b1, 2'b01, 32'h206, 32'h0, 1'b0, 1'b1);
        drv(1'b1, 2'b01, 32'h207, 32'h0, 1'b0, 1'b1);
        n_checks++; if (if0.pc_o !== 32'h204 || if0.misalign_o !== 1'b1) begin n_fail++; $display("FAIL mis_c0_206 got pc %h m%b exp pc %h m1", if0.pc_o, if0.misalign_o, 32'h204); end
        n_checks++; if (if1.pc_o !== 32'h206 || if1.misalign_o !== 1'b0) begin n_fail++; $display("FAIL mis_c1_206 got pc %h m%b exp pc %h m0", if1.pc_o, if1.misalign_o, 32'h206); end
        drv(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
        n_checks++; if (if1.pc_o !== 32'h206 || if1.misalign_o !== 1'b1) begin n_fail++; $display("FAIL mis_c1_207 got pc %h m%b exp pc %h m1", if1.pc_o, if1.misalign_o, 32'h206); end
        n_checks++; if (if0.pc_o !== 32'h204 || if0.misalign_o !== 1'b1 || if0.flush_o !== 1'b1) begin n_fail++; $display("FAIL mis_c0_207 got pc %h m%b f%b exp pc %h m1 f1", if0.pc_o, if0.misalign_o, if0.flush_o, 32'h204); end
        drv(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
        n_checks++; if (if0.misalign_o !== 1'b0 || if1.misalign_o !== 1'b0 || if0.flush_o !== 1'b0) begin n_fail++; $display("FAIL mis_clear got m%b%b f%b exp m00 f0", if0.misalign_o, if1.misalign_o, if0.flush_o); end
    endtask

    task automatic test_compressed;
        logic [2:0] pat;
        pat = 3'b101;
        drv(1'b1, 2'b01, 32'h10, 32'h0, 1'b0, 1'b1);
        q0.push_back(32'h10); q0.push_back(32'h14); q0.push_back(32'h18);
        q1.push_back(32'h10); q1.push_back(32'h12); q1.push_back(32'h16);
        sb_on = 1'b1;
        for (int i = 0; i < 3; i++) drv(1'b0, 2'b00, 32'h0, 32'h0, pat[i], 1'b1);
        drv(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
        sb_on = 1'b0;
        n_checks++; if (if0.pc_o !== 32'h1C) begin n_fail++; $display("FAIL cstep_c0 got %h exp %h", if0.pc_o, 32'h1C); end
        n_checks++; if (if1.pc_o !== 32'h18) begin n_fail++; $display("FAIL cstep_c1 got %h exp %h", if1.pc_o, 32'h18); end
        n_checks++; if (q0.size() != 0 || q1.size() != 0) begin n_fail++; $display("FAIL cstep_sb_drain got %0d/%0d exp 0/0", q0.size(), q1.size()); end
    endtask

    task automatic test_wrap_reset;
        drv(1'b1, 2'b01, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b1);
        q0.push_back(32'hFFFF_FFFC); q1.push_back(32'hFFFF_FFFC);
        q0.push_back(32'h0);         q1.push_back(32'h0);
        sb_on = 1'b1;
        drv(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
        drv(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
        n_checks++; if (if0.pc_o !== 32'h0 || if1.pc_o !== 32'h0) begin n_fail++; $display("FAIL wrap got %h/%h exp 0", if0.pc_o, if1.pc_o); end
        @(negedge clk); #1;
        rstn = 1'b0;
        #1;
        n_checks++; if (if0.pc_o !== 32'h8000_0000 || if1.pc_o !== 32'h8000_0000) begin n_fail++; $display("FAIL async_rst got %h/%h exp %h", if0.pc_o, if1.pc_o, 32'h8000_0000); end
        n_checks++; if (if0.fetch_valid_o !== 1'b0) begin n_fail++; $display("FAIL async_rst_valid got %b exp 0", if0.fetch_valid_o); end
        @(posedge clk); #1;
        rstn = 1'b1;
        #1;
        n_checks++; if (if0.fetch_valid_o !== 1'b0 || if1.fetch_valid_o !== 1'b0) begin n_fail++; $display("FAIL reboot_valid got %b%b exp 00", if0.fetch_valid_o, if1.fetch_valid_o); end
        q0.push_back(32'h8000_0000); q1.push_back(32'h8000_0000);
        drv(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
        n_checks++; if (if0.fetch_valid_o !== 1'b1) begin n_fail++; $display("FAIL reboot_run got %b exp 1", if0.fetch_valid_o); end
        drv(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
        sb_on = 1'b0;
        n_checks++; if (q0.size() != 0 || q1.size() != 0) begin n_fail++; $display("FAIL wrap_sb_drain got %0d/%0d exp 0/0", q0.size(), q1.size()); end
    endtask

    initial begin
        test_reset();
        test_backpressure();
        test_simultaneous();
        test_misaligned();
        test_compressed();
        test_wrap_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
